riscv_dbus_arbiter: RTL and testbench
=====================================

# riscv_dbus_arbiter

Two-master arbiter and sequencer for the data-bus port of `riscv_io_bridge`, which is the data cache plus memory-mapped I/O. The core's load/store unit (master 0) and the debug/DMA master (master 1) each present a request. The block grants one master at a time with round-robin fairness. It drives the single slave port for exactly one transaction and returns read data with a one-cycle valid pulse. It sits between the pipeline MEM stage and `riscv_io_bridge`.

## Interface
- `RD_LAT`, default 1: cycles from slave address presentation to valid `s_rdata` (0..3).
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `m0_req` / `m1_req` input 1: request; held with its attributes until `mX_gnt`.
- `m0_we` / `m1_we` input 1: 1 = write, 0 = read.
- `m0_write` / `m1_write` input `CACHE_D_WRITE_LEN`: write size code (SW/SH/SB).
- `m0_addr` / `m1_addr` input 32: byte address.
- `m0_wdata` / `m1_wdata` input 32: write data.
- `m0_gnt` / `m1_gnt` output 1: one-cycle pulse; the request has been accepted.
- `m0_done` / `m1_done` output 1: one-cycle pulse; the transaction is complete (read data valid).
- `m_rdata` output 32: read data, valid during `mX_done` of a read.
- `s_write_en` output 1: to `cache_d_write_en`.
- `s_write` output `CACHE_D_WRITE_LEN`: to `cache_d_write`.
- `s_addr` output 32: to `addr`.
- `s_wdata` output 32: to `data_to_cache`.
- `s_rdata` input 32: from `data_out`.

## Operation
- FSM states:
  - IDLE: arbitrate among requests.
  - ACCESS: drive the slave; pulse gnt.
  - WAIT: count RD_LAT−1 further cycles; used by reads only.
  - DONE: pulse done; re-arbitrate.
- IDLE/DONE with any request: select a winner, latch its we/write/addr/wdata into command registers, and go to ACCESS. With no request, go to (or stay in) IDLE.
- Round-robin: a 1-bit `last` register records the most recently granted master. On simultaneous requests, grant `~last`. A single requester always wins. `last` updates on gnt.
- ACCESS, write:
  - `s_write_en`=1 for this cycle only.
  - Next state DONE.
- ACCESS, read:
  - `s_write_en`=0.
  - If RD_LAT≤1, capture `s_rdata` at the end of ACCESS (RD_LAT=0) or the end of the first WAIT cycle (RD_LAT=1).
  - In general, capture at the end of cycle ACCESS+RD_LAT, then go to DONE.
- `s_addr`/`s_write`/`s_wdata` come from the command registers and are stable from ACCESS through DONE. They hold their last value in IDLE. `s_write_en` is 0 outside ACCESS.
- `m_rdata` holds the captured value until the next read capture. For writes it is not updated.
- A master must not change its request attributes between req and gnt. It may deassert req only after gnt. It may issue a new req in the cycle after its gnt; that request is arbitrated in DONE.

## Timing
- Reset values:
  - state=IDLE, `last`=1 (so master 0 wins the first tie).
  - All gnt/done outputs and `s_write_en` = 0.
  - `s_addr`, `s_wdata`, `m_rdata` = 0; `s_write` = SW code.
- Request sampled in cycle T (IDLE) → gnt and slave drive in T+1.
- Write done pulse at T+2.
- Read done pulse at T+2+max(RD_LAT,0), with RD_LAT=0 giving T+2.
- Back-to-back: a request pending in DONE enters ACCESS the next cycle, so there is no idle bubble. Sustained writes run at one every 2 cycles.
- Reset asserted mid-transaction: abort. No done pulse, `s_write_en` falls the same edge, state=IDLE. A write already in ACCESS at that edge is not retried.
- Only one gnt and at most one done are ever high per cycle. gnt and done of different masters may coincide only when arbitration happens in DONE (done for the old master, then gnt next cycle). They never coincide in the same cycle.

## Structure
- Shared in `riscv_defs.v`:
  - state encodings `DBUS_ARB_IDLE/ACCESS/WAIT/DONE`;
  - existing `CACHE_D_WRITE_*` codes and `CACHE_D_WRITE_LEN`.
- Sub-module `riscv_rr_arbiter2`: combinational 2-way round-robin pick plus the registered `last` pointer, with an update strobe.
- The top level holds the FSM, RD_LAT counter, command registers and read-capture register.

## Test plan
- Single write: m0 writes SW 0x12345678 to 0xfffffc04 → gnt at T+1 with `s_write_en`=1, `s_addr`=0xfffffc04, `s_wdata`=0x12345678; done at T+2; `s_write_en` low afterwards.
- Single read, RD_LAT=1: m1 reads 0xfffffc00 while the bench drives `s_rdata`=0x00a5a5a5 → m1_done at T+3 with `m_rdata`=0x00a5a5a5.
- Simultaneous requests after reset: both req at T → m0 granted T+1, m1 granted T+3 (from DONE). Repeat with both held → grants alternate 0,1,0,1.
- Back-to-back: m0 issues 4 consecutive SB writes → 4 gnts spaced 2 cycles, no IDLE between, `s_write` = SB code each time.
- Reset mid-read (RD_LAT=3): `rst` asserted in WAIT → no done pulse, state IDLE, outputs at reset values; a subsequent m1 read completes normally.
- RD_LAT=0 sweep: read latency equals 2 cycles; the value captured is the `s_rdata` present during ACCESS.

Source files
------------

// File: rtl/riscv_dbus_arbiter_pkg.sv
// riscv_dbus_arbiter_pkg
//   Shared definitions for the data-bus arbiter: write-size codes and their
//   width (mirroring the cache write encoding), data width, the arbiter
//   state encoding and the two-way round-robin pick function.
package riscv_dbus_arbiter_pkg;

   localparam int DATA_W            = 32;
   localparam int CACHE_D_WRITE_LEN = 2;

   localparam logic [CACHE_D_WRITE_LEN-1:0] CACHE_D_WRITE_SB = 2'd0;
   localparam logic [CACHE_D_WRITE_LEN-1:0] CACHE_D_WRITE_SH = 2'd1;
   localparam logic [CACHE_D_WRITE_LEN-1:0] CACHE_D_WRITE_SW = 2'd2;

   typedef enum logic [1:0] {
      DBUS_ARB_IDLE   = 2'd0,
      DBUS_ARB_ACCESS = 2'd1,
      DBUS_ARB_WAIT   = 2'd2,
      DBUS_ARB_DONE   = 2'd3
   } dbus_arb_state_t;

   // Index of the winning master. A lone requester always wins; on a tie the
   // master that was not granted last time wins.
   function automatic logic rr_pick(input logic [1:0] req, input logic last);
      logic pick;
      case (req)
         2'b11:   pick = ~last;
         2'b10:   pick = 1'b1;
         default: pick = 1'b0;
      endcase
      return pick;
   endfunction

endpackage

// File: rtl/riscv_dbus_arbiter_if.sv
// riscv_dbus_arbiter_if
//   Bundle of the two master request ports and the single slave port.
//   modport slave  : the arbiter's view (takes requests, drives the slave).
//   modport master : the requesters' and memory's view (the reverse).
interface riscv_dbus_arbiter_if;
   import riscv_dbus_arbiter_pkg::*;

   logic                         m0_req,   m1_req;
   logic                         m0_we,    m1_we;
   logic [CACHE_D_WRITE_LEN-1:0] m0_write, m1_write;
   logic [DATA_W-1:0]            m0_addr,  m1_addr;
   logic [DATA_W-1:0]            m0_wdata, m1_wdata;
   logic                         m0_gnt,   m1_gnt;
   logic                         m0_done,  m1_done;
   logic [DATA_W-1:0]            m_rdata;

   logic                         s_write_en;
   logic [CACHE_D_WRITE_LEN-1:0] s_write;
   logic [DATA_W-1:0]            s_addr;
   logic [DATA_W-1:0]            s_wdata;
   logic [DATA_W-1:0]            s_rdata;

   modport slave (
      input  m0_req, m1_req, m0_we, m1_we, m0_write, m1_write,
             m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata,
      output m0_gnt, m1_gnt, m0_done, m1_done, m_rdata,
             s_write_en, s_write, s_addr, s_wdata
   );

   modport master (
      output m0_req, m1_req, m0_we, m1_we, m0_write, m1_write,
             m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata,
      input  m0_gnt, m1_gnt, m0_done, m1_done, m_rdata,
             s_write_en, s_write, s_addr, s_wdata
   );

endinterface

// File: rtl/riscv_rr_arbiter2.sv
// riscv_rr_arbiter2
//   Two-way round-robin arbiter: combinational pick plus registered pointer
//   to the most recently granted master.
//   clk, rst : clock, synchronous active-high reset (pointer -> master 1)
//   req      : request vector {m1, m0}
//   upd      : strobe; load upd_idx into the pointer
//   upd_idx  : index of the master just granted
//   any      : at least one request is present
//   pick     : index of the winner
module riscv_rr_arbiter2
   import riscv_dbus_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       upd_idx,
   output logic       any,
   output logic       pick
);

   logic last_q;

   assign any  = |req;
   assign pick = rr_pick(req, last_q);

   // Reset to master 1 so master 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst)
         last_q <= 1'b1;
      else if (upd)
         last_q <= upd_idx;
   end

endmodule

// File: rtl/riscv_dbus_arbiter.sv
// riscv_dbus_arbiter
//   Grants the data-bus slave port to one of two masters at a time
//   (round-robin), runs exactly one slave transaction and reports completion
//   with a one-cycle done pulse carrying read data.
//   RD_LAT : cycles from slave address to valid s_rdata (0..3)
//   clk    : system clock
//   rst    : synchronous active-high reset; aborts any transaction
//   bus    : master request ports and slave port (slave modport)
module riscv_dbus_arbiter
   import riscv_dbus_arbiter_pkg::*;
#(
   parameter int RD_LAT = 1
)
(
   input  logic                 clk,
   input  logic                 rst,
   riscv_dbus_arbiter_if.slave  bus
);

   // WAIT lasts RD_LAT cycles; the counter runs from RD_LAT-1 down to 0.
   localparam logic [1:0] WAIT_LOAD = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

   dbus_arb_state_t              state_q, state_d;
   logic [1:0]                   cnt_q, cnt_d;
   logic                         cmd_mst_q;
   logic                         cmd_we_q;
   logic [CACHE_D_WRITE_LEN-1:0] cmd_write_q;
   logic [DATA_W-1:0]            cmd_addr_q;
   logic [DATA_W-1:0]            cmd_wdata_q;
   logic [DATA_W-1:0]            rdata_q;
   logic                         arb_any;
   logic                         arb_pick;
   logic                         load_cmd;
   logic                         capture;

   riscv_rr_arbiter2 u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     ({bus.m1_req, bus.m0_req}),
      .upd     (state_q == DBUS_ARB_ACCESS),
      .upd_idx (cmd_mst_q),
      .any     (arb_any),
      .pick    (arb_pick)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      load_cmd = 1'b0;
      capture  = 1'b0;
      case (state_q)
         DBUS_ARB_IDLE: begin
            if (arb_any) begin
               load_cmd = 1'b1;
               state_d  = DBUS_ARB_ACCESS;
            end
         end
         DBUS_ARB_ACCESS: begin
            if (cmd_we_q) begin
               state_d = DBUS_ARB_DONE;
            end else if (RD_LAT == 0) begin
               capture = 1'b1;
               state_d = DBUS_ARB_DONE;
            end else begin
               cnt_d   = WAIT_LOAD;
               state_d = DBUS_ARB_WAIT;
            end
         end
         DBUS_ARB_WAIT: begin
            if (cnt_q == 2'd0) begin
               capture = 1'b1;
               state_d = DBUS_ARB_DONE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         DBUS_ARB_DONE: begin
            // Re-arbitrate here so back-to-back requests see no idle bubble.
            if (arb_any) begin
               load_cmd = 1'b1;
               state_d  = DBUS_ARB_ACCESS;
            end else begin
               state_d = DBUS_ARB_IDLE;
            end
         end
         default: state_d = DBUS_ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= DBUS_ARB_IDLE;
         cnt_q       <= 2'd0;
         cmd_mst_q   <= 1'b0;
         cmd_we_q    <= 1'b0;
         cmd_write_q <= CACHE_D_WRITE_SW;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load_cmd) begin
            cmd_mst_q   <= arb_pick;
            cmd_we_q    <= arb_pick ? bus.m1_we    : bus.m0_we;
            cmd_write_q <= arb_pick ? bus.m1_write : bus.m0_write;
            cmd_addr_q  <= arb_pick ? bus.m1_addr  : bus.m0_addr;
            cmd_wdata_q <= arb_pick ? bus.m1_wdata : bus.m0_wdata;
         end
         if (capture)
            rdata_q <= bus.s_rdata;
      end
   end

   assign bus.m0_gnt     = (state_q == DBUS_ARB_ACCESS) && !cmd_mst_q;
   assign bus.m1_gnt     = (state_q == DBUS_ARB_ACCESS) &&  cmd_mst_q;
   assign bus.m0_done    = (state_q == DBUS_ARB_DONE)   && !cmd_mst_q;
   assign bus.m1_done    = (state_q == DBUS_ARB_DONE)   &&  cmd_mst_q;
   assign bus.m_rdata    = rdata_q;
   assign bus.s_write_en = (state_q == DBUS_ARB_ACCESS) && cmd_we_q;
   assign bus.s_write    = cmd_write_q;
   assign bus.s_addr     = cmd_addr_q;
   assign bus.s_wdata    = cmd_wdata_q;

endmodule

// File: tb/tb_riscv_dbus_arbiter.sv
module tb_riscv_dbus_arbiter;
   import riscv_dbus_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic rst3;
   always #5 clk = ~clk;

   riscv_dbus_arbiter_if bus1 ();
   riscv_dbus_arbiter_if bus3 ();
   riscv_dbus_arbiter_if bus0 ();

   riscv_dbus_arbiter #(.RD_LAT(1)) dut1 (.clk(clk), .rst(rst),  .bus(bus1));
   riscv_dbus_arbiter #(.RD_LAT(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));
   riscv_dbus_arbiter #(.RD_LAT(0)) dut0 (.clk(clk), .rst(rst),  .bus(bus0));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        mst;
      logic        we;
      logic [1:0]  wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] exp_rdata;
      int          exp_done;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic mst, input logic req, input logic we,
                         input logic [1:0] wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
      if (mst) begin
         bus1.m1_req = req; bus1.m1_we = we; bus1.m1_write = wr;
         bus1.m1_addr = addr; bus1.m1_wdata = wdata;
      end else begin
         bus1.m0_req = req; bus1.m0_we = we; bus1.m0_write = wr;
         bus1.m0_addr = addr; bus1.m0_wdata = wdata;
      end
   endtask

   function automatic logic [3:0] flags1();
      return {bus1.m0_gnt, bus1.m1_gnt, bus1.m0_done, bus1.m1_done};
   endfunction

   initial begin
      int g, d, k;
      logic [3:0] f, ef;

      rst = 1'b1; rst3 = 1'b1;
      drive1(1'b0, 1'b0, 1'b0, CACHE_D_WRITE_SW, 32'h0, 32'h0);
      drive1(1'b1, 1'b0, 1'b0, CACHE_D_WRITE_SW, 32'h0, 32'h0);
      bus1.s_rdata = 32'h0;
      bus3.m0_req = 0; bus3.m0_we = 0; bus3.m0_write = CACHE_D_WRITE_SW;
      bus3.m0_addr = 0; bus3.m0_wdata = 0;
      bus3.m1_req = 0; bus3.m1_we = 0; bus3.m1_write = CACHE_D_WRITE_SW;
      bus3.m1_addr = 0; bus3.m1_wdata = 0; bus3.s_rdata = 0;
      bus0.m0_req = 0; bus0.m0_we = 0; bus0.m0_write = CACHE_D_WRITE_SW;
      bus0.m0_addr = 0; bus0.m0_wdata = 0;
      bus0.m1_req = 0; bus0.m1_we = 0; bus0.m1_write = CACHE_D_WRITE_SW;
      bus0.m1_addr = 0; bus0.m1_wdata = 0; bus0.s_rdata = 0;

      vecs[0] = '{1'b0, 1'b1, CACHE_D_WRITE_SW, 32'hfffffc04, 32'h12345678, 32'hdeadbeef, 32'h00000000, 2};
      vecs[1] = '{1'b1, 1'b0, CACHE_D_WRITE_SW, 32'hfffffc00, 32'h0,        32'h00a5a5a5, 32'h00a5a5a5, 3};
      vecs[2] = '{1'b1, 1'b1, CACHE_D_WRITE_SH, 32'h00000100, 32'h0000beef, 32'h11111111, 32'h00a5a5a5, 2};
      vecs[3] = '{1'b0, 1'b0, CACHE_D_WRITE_SW, 32'h00002000, 32'h0,        32'hcafef00d, 32'hcafef00d, 3};
      vecs[4] = '{1'b0, 1'b1, CACHE_D_WRITE_SB, 32'h00000003, 32'h00000055, 32'h22222222, 32'hcafef00d, 2};
      vecs[5] = '{1'b1, 1'b0, CACHE_D_WRITE_SW, 32'h00000004, 32'h0,        32'h00000000, 32'h00000000, 3};

      repeat (3) tick();

      // Reset state
      chk("rst flags",      {28'h0, flags1()}, 32'h0);
      chk("rst s_write_en", {31'h0, bus1.s_write_en}, 32'h0);
      chk("rst s_addr",     bus1.s_addr, 32'h0);
      chk("rst s_wdata",    bus1.s_wdata, 32'h0);
      chk("rst s_write",    {30'h0, bus1.s_write}, {30'h0, CACHE_D_WRITE_SW});
      chk("rst m_rdata",    bus1.m_rdata, 32'h0);
      rst = 1'b0; rst3 = 1'b0;
      tick();

      // Simultaneous requests held: grants alternate 0,1,0,1
      drive1(1'b0, 1'b1, 1'b1, CACHE_D_WRITE_SW, 32'h10, 32'ha0);
      drive1(1'b1, 1'b1, 1'b1, CACHE_D_WRITE_SW, 32'h20, 32'hb0);
      for (int c = 1; c <= 8; c++) begin
         tick();
         f  = flags1();
         ef = {(c == 1 || c == 5), (c == 3 || c == 7), (c == 2 || c == 6), (c == 4 || c == 8)};
         chk($sformatf("alt flags c%0d", c), {28'h0, f}, {28'h0, ef});
         if (f[3] || f[2])
            chk($sformatf("alt s_addr c%0d", c), bus1.s_addr, f[3] ? 32'h10 : 32'h20);
         if (c == 7) begin
            bus1.m0_req = 1'b0;
            bus1.m1_req = 1'b0;
         end
      end
      tick();
      chk("alt idle flags", {28'h0, flags1()}, 32'h0);

      // Table-driven single transactions (RD_LAT=1)
      for (int i = 0; i < 6; i++) begin
         g = 0; d = 0;
         bus1.s_rdata = ~vecs[i].rdata;
         drive1(vecs[i].mst, 1'b1, vecs[i].we, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         for (int c = 1; c <= 8; c++) begin
            tick();
            bus1.s_rdata = (c == 2) ? vecs[i].rdata : ~vecs[i].rdata;
            f = flags1();
            chk($sformatf("v%0d other c%0d", i, c), {30'h0, vecs[i].mst ? {f[3], f[1]} : {f[2], f[0]}}, 32'h0);
            if ((vecs[i].mst ? f[2] : f[3]) && g == 0) begin
               g = c;
               chk($sformatf("v%0d s_addr", i),     bus1.s_addr,  vecs[i].addr);
               chk($sformatf("v%0d s_write", i),    {30'h0, bus1.s_write}, {30'h0, vecs[i].wr});
               chk($sformatf("v%0d s_write_en", i), {31'h0, bus1.s_write_en}, {31'h0, vecs[i].we});
               if (vecs[i].we)
                  chk($sformatf("v%0d s_wdata", i), bus1.s_wdata, vecs[i].wdata);
               drive1(vecs[i].mst, 1'b0, vecs[i].we, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            end
            if ((vecs[i].mst ? f[0] : f[1]) && d == 0) begin
               d = c;
               chk($sformatf("v%0d m_rdata", i), bus1.m_rdata, vecs[i].exp_rdata);
               chk($sformatf("v%0d done we", i), {31'h0, bus1.s_write_en}, 32'h0);
               chk($sformatf("v%0d done s_addr", i), bus1.s_addr, vecs[i].addr);
            end
         end
         chk($sformatf("v%0d gnt cycle", i),  g, 1);
         chk($sformatf("v%0d done cycle", i), d, vecs[i].exp_done);
         chk($sformatf("v%0d idle s_addr", i), bus1.s_addr, vecs[i].addr);
      end

      // Back-to-back SB writes from m0: one grant every 2 cycles
      k = 0;
      drive1(1'b0, 1'b1, 1'b1, CACHE_D_WRITE_SB, 32'h40, 32'h0);
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (bus1.m0_gnt) begin
            chk($sformatf("b2b gnt%0d cycle", k), c, 1 + 2 * k);
            chk($sformatf("b2b gnt%0d s_addr", k), bus1.s_addr, 32'h40 + k);
            chk($sformatf("b2b gnt%0d s_write", k), {30'h0, bus1.s_write}, {30'h0, CACHE_D_WRITE_SB});
            chk($sformatf("b2b gnt%0d s_write_en", k), {31'h0, bus1.s_write_en}, 32'h1);
            k++;
            if (k == 4)
               drive1(1'b0, 1'b0, 1'b1, CACHE_D_WRITE_SB, 32'h40, 32'h0);
            else
               drive1(1'b0, 1'b1, 1'b1, CACHE_D_WRITE_SB, 32'h40 + k, k);
         end
      end
      chk("b2b gnt count", k, 4);
      chk("b2b final s_write_en", {31'h0, bus1.s_write_en}, 32'h0);

      // RD_LAT=3: full read captures the data present at ACCESS+3
      g = 0; d = 0;
      bus3.m1_req = 1'b1; bus3.m1_we = 1'b0; bus3.m1_addr = 32'h80;
      for (int c = 1; c <= 10; c++) begin
         tick();
         bus3.s_rdata = 32'h30000000 | c;
         if (bus3.m1_gnt && g == 0) begin g = c; bus3.m1_req = 1'b0; end
         if (bus3.m1_done && d == 0) begin
            d = c;
            chk("lat3 m_rdata", bus3.m_rdata, 32'h30000004);
         end
      end
      chk("lat3 gnt cycle", g, 1);
      chk("lat3 done cycle", d, 5);

      // RD_LAT=3: reset asserted in WAIT aborts the read
      d = 0;
      bus3.m1_req = 1'b1; bus3.m1_addr = 32'h84;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (bus3.m1_gnt) bus3.m1_req = 1'b0;
         if (c == 2) rst3 = 1'b1;
         if (c == 3) begin
            chk("abort flags", {28'h0, bus3.m0_gnt, bus3.m1_gnt, bus3.m0_done, bus3.m1_done}, 32'h0);
            chk("abort s_write_en", {31'h0, bus3.s_write_en}, 32'h0);
            chk("abort s_addr", bus3.s_addr, 32'h0);
            chk("abort s_write", {30'h0, bus3.s_write}, {30'h0, CACHE_D_WRITE_SW});
            chk("abort m_rdata", bus3.m_rdata, 32'h0);
            rst3 = 1'b0;
         end
         if (bus3.m1_done) d++;
      end
      chk("abort done count", d, 0);

      // RD_LAT=3: subsequent read completes normally
      g = 0; d = 0;
      bus3.m1_req = 1'b1; bus3.m1_addr = 32'h88;
      for (int c = 1; c <= 10; c++) begin
         tick();
         bus3.s_rdata = 32'h38000000 | c;
         if (bus3.m1_gnt && g == 0) begin
            g = c; bus3.m1_req = 1'b0;
            chk("post s_addr", bus3.s_addr, 32'h88);
         end
         if (bus3.m1_done && d == 0) begin
            d = c;
            chk("post m_rdata", bus3.m_rdata, 32'h38000004);
         end
      end
      chk("post gnt cycle", g, 1);
      chk("post done cycle", d, 5);

      // RD_LAT=0: capture the data present during ACCESS
      g = 0; d = 0;
      bus0.m0_req = 1'b1; bus0.m0_we = 1'b0; bus0.m0_addr = 32'h90;
      bus0.s_rdata = 32'h50000000;
      for (int c = 1; c <= 6; c++) begin
         tick();
         bus0.s_rdata = 32'h50000000 | c;
         if (bus0.m0_gnt && g == 0) begin g = c; bus0.m0_req = 1'b0; end
         if (bus0.m0_done && d == 0) begin
            d = c;
            chk("lat0 m_rdata", bus0.m_rdata, 32'h50000001);
         end
      end
      chk("lat0 gnt cycle", g, 1);
      chk("lat0 done cycle", d, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
